// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI write-only register slave.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;
    localparam int         NUM_REGS       = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        COMMIT
    } state_t;

    function automatic logic addr_in_range(input logic [6:0] addr);
        return addr <= ADDR_DUTY;
    endfunction

endpackage

// File: rtl/spi_reg_slave_sync_edge_detect.sv
// Pin synchroniser with a delay flop; rise/fall are registered single-cycle pulses.
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            dly   <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            dly   <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~dly;
            fall  <= ~chain[SYNC_STAGES-1] & dly;
        end
    end

    assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// Write-only SPI mode-0 register slave feeding the PWM peripheral control inputs.
//   state  | meaning
//   IDLE   | waiting for chip select to fall
//   ACTIVE | shifting copi on each sclk rise until chip select rises
//   COMMIT | one cycle: validate frame, write register or flag error
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'd17;

    logic sclk_s, sclk_rise, sclk_fall_unused;
    logic ncs_s_unused, ncs_rise, ncs_fall;
    logic copi_s, copi_rise_unused, copi_fall_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall_unused)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk  (clk),
        .rst  (rst),
        .din  (ncs),
        .dout (ncs_s_unused),
        .rise (ncs_rise),
        .fall (ncs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk  (clk),
        .rst  (rst),
        .din  (copi),
        .dout (copi_s),
        .rise (copi_rise_unused),
        .fall (copi_fall_unused)
    );

    logic                  sclk_s_unused;
    assign sclk_s_unused = sclk_s;

    state_t                state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [4:0]            bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
            wr_strobe       <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A coincident sclk rise is dropped: the count starts from zero.
                    if (ncs_fall) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (bit_cnt != CNT_FULL) begin
                        frame_err <= 1'b1;
                    end else if (shift_reg[15] && addr_in_range(shift_reg[14:8])) begin
                        wr_strobe <= 1'b1;
                        case (shift_reg[14:8])
                            ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift_reg[7:0];
                            ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift_reg[7:0];
                            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shift_reg[7:0];
                            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shift_reg[7:0];
                            ADDR_DUTY:      pwm_duty_cycle  <= shift_reg[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
